// File: rtl/axis_misr_sink.sv
// AXI-stream style sink that folds each frame of N coefficients into a MISR signature.
// Optional macro AXIS_MISR_SINK_EXPECT_EN adds exp_sig / sig_ok signature comparison.
module axis_misr_sink #(
  parameter int          N    = 16,
  parameter int          QW   = 64,
  parameter logic [63:0] SEED = 64'hFFFFFFFFFFFFFFFF,
  parameter logic [63:0] POLY = 64'h000000000000001B
) (
  input  logic          clk,
  input  logic          s_rst_n,
  input  logic          z_vld,
  output logic          z_rdy,
  input  logic [QW-1:0] z,
  input  logic          z_last,
`ifdef AXIS_MISR_SINK_EXPECT_EN
  input  logic [QW-1:0] exp_sig,
  output logic          sig_ok,
`endif
  output logic [QW-1:0] sig,
  output logic          sig_vld,
  output logic [15:0]   frame_cnt,
  output logic          err_len,
  output logic          busy
);

  localparam int              BW       = (N > 2) ? $clog2(N) : 1;
  localparam logic [BW-1:0]   LAST_IDX = BW'(N - 1);
  localparam logic [QW-1:0]   SEED_Q   = SEED[QW-1:0];
  localparam logic [QW-1:0]   POLY_Q   = POLY[QW-1:0];

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t        state;
  logic [BW-1:0] bidx;
  logic [QW-1:0] m;
  logic [QW-1:0] m_shift;
  logic [QW-1:0] m_next;
  logic          accept;
  logic          at_last_idx;
  logic          frame_end;

  // Handshake: a beat transfers on any rising edge where z_vld && z_rdy;
  // z_rdy is low only in reset and high every cycle afterwards.
  assign accept      = z_vld && z_rdy;
  assign at_last_idx = (bidx == LAST_IDX);
  assign frame_end   = accept && (z_last || at_last_idx);
  assign busy        = (state == ACTIVE);

  always_comb begin
    m_shift = {m[QW-2:0], 1'b0};
    if (m[QW-1]) begin
      m_shift = m_shift ^ POLY_Q;
    end
    m_next = m_shift ^ z;
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state     <= IDLE;
      z_rdy     <= 1'b0;
      bidx      <= '0;
      m         <= SEED_Q;
      sig       <= '0;
      sig_vld   <= 1'b0;
      frame_cnt <= 16'd0;
      err_len   <= 1'b0;
`ifdef AXIS_MISR_SINK_EXPECT_EN
      sig_ok    <= 1'b0;
`endif
    end else begin
      z_rdy   <= 1'b1;
      sig_vld <= 1'b0;
      if (frame_end) begin
        // Close the frame and restart the MISR so the next beat needs no bubble.
        state     <= IDLE;
        sig       <= m_next;
        m         <= SEED_Q;
        bidx      <= '0;
        frame_cnt <= frame_cnt + 16'd1;
        sig_vld   <= 1'b1;
        if (z_last != at_last_idx) begin
          err_len <= 1'b1;
        end
`ifdef AXIS_MISR_SINK_EXPECT_EN
        sig_ok    <= (m_next == exp_sig);
`endif
      end else if (accept) begin
        state <= ACTIVE;
        m     <= m_next;
        bidx  <= bidx + 1'b1;
      end
    end
  end

endmodule

// File: doc/axis_misr_sink.md
AXIS_MISR_SINK -- requirements
Module: axis_misr_sink

Interface
REQ-001 SHALL have parameter N, default 16, coefficients per frame (N >= 2).
REQ-002 SHALL have parameter QW, default 64, data width of z.
REQ-003 SHALL have parameter SEED, default 64'hFFFFFFFFFFFFFFFF, MISR start value (low QW bits used).
REQ-004 SHALL have parameter POLY, default 64'h000000000000001B, MISR feedback polynomial (low QW bits used).
REQ-005 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-006 SHALL have port s_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port z_vld  input  1  upstream beat valid.
REQ-008 SHALL have port z_rdy  output  1  sink ready.
REQ-009 SHALL have port z  input  QW  coefficient data.
REQ-010 SHALL have port z_last  input  1  upstream end-of-frame marker.
REQ-011 SHALL have port sig  output  QW  signature of the last completed frame.
REQ-012 SHALL have port sig_vld  output  1  one-cycle pulse, new sig available.
REQ-013 SHALL have port frame_cnt  output  16  completed frames, wraps 16'hFFFF -> 0.
REQ-014 SHALL have port err_len  output  1  sticky frame-length error.
REQ-015 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-016 SHALL accept a beat when z_vld && z_rdy; z_rdy is 1 every cycle after reset release (producer assumes an always-ready sink).
REQ-017 SHALL implement FSM IDLE/ACTIVE: IDLE -> ACTIVE on an accepted beat that does not end the frame; ACTIVE -> IDLE on the frame-ending beat; a frame-ending beat in IDLE (single-beat frame) stays IDLE.
REQ-018 SHALL keep beat index bidx (0..N-1), reset to 0 at every frame end.
REQ-019 SHALL end a frame on the accepted beat where z_last = 1 or bidx = N-1, whichever comes first.
REQ-020 SHALL set err_len when z_last and (bidx = N-1) disagree on the frame-ending beat; err_len clears only on reset.
REQ-021 SHALL update MISR m per accepted beat: t = m << 1 (QW bits); if m[QW-1] then t ^= POLY; m_next = t ^ z.
REQ-022 SHALL, on the frame-ending beat, load sig with m_next, reload m with SEED in the same cycle, increment frame_cnt, and assert sig_vld on the following cycle for exactly one cycle.
REQ-023 SHALL accept the first beat of the next frame in the cycle directly after a frame end with no bubble, using SEED as m.
REQ-024 SHALL hold sig unchanged between frame ends; no beat accepted when z_vld = 0 leaves all state unchanged.
REQ-025 SHALL drive busy = 1 exactly when the FSM is ACTIVE.

Reset
REQ-026 SHALL, while s_rst_n = 0, force z_rdy=0, sig=0, sig_vld=0, frame_cnt=0, err_len=0, busy=0, bidx=0, m=SEED, FSM=IDLE, asynchronously.
REQ-027 SHALL discard a partial frame on reset assertion mid-frame, with no sig_vld pulse for it.
REQ-028 SHALL assert z_rdy on the first rising clk edge after s_rst_n deasserts.

Configuration
REQ-029 SHALL, with macro AXIS_MISR_SINK_EXPECT_EN defined, add input exp_sig (QW) and output sig_ok (1): sig_ok updates with sig_vld to (m_next == exp_sig) sampled on the frame-ending beat, reset value 0.
REQ-030 SHALL, without AXIS_MISR_SINK_EXPECT_EN, omit exp_sig and sig_ok entirely, all other behaviour identical.

Verification (N=4, QW=8, SEED=8'hFF, POLY=8'h1D)
REQ-031 SHALL cover: 4 beats z=0, z_last on beat 4 -> sig=8'h4B, sig_vld one cycle after beat 4, frame_cnt=1, err_len=0.
REQ-032 SHALL cover: two 4-beat zero frames back-to-back, z_vld held high -> z_rdy never low, two sig_vld pulses 4 cycles apart, both sig=8'h4B, frame_cnt=2.
REQ-033 SHALL cover: z_last on beat 2 -> frame ends, err_len=1, bidx=0, next 4-beat zero frame gives sig=8'h4B with err_len still 1.
REQ-034 SHALL cover: 4 zero beats without z_last -> frame ends at beat 4, sig=8'h4B, err_len=1.
REQ-035 SHALL cover: s_rst_n low after beat 2 -> all outputs at reset values, no sig_vld; subsequent 4-beat zero frame gives sig=8'h4B, frame_cnt=1.
REQ-036 SHALL cover, with AXIS_MISR_SINK_EXPECT_EN: exp_sig=8'h4B on a zero frame -> sig_ok=1; exp_sig=8'h4C -> sig_ok=0.
